// File: rtl/eth_gmii_tx_framer.sv
// Ethernet TX framing stage: preamble/SFD, payload with zero padding, CRC-32 FCS and
// inter-frame gap, driving registered GMII txen/txd.
module eth_gmii_tx_framer #(
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned IFG_BYTES       = 12
) (
    input  logic       gmii_txc,
    input  logic       rst_n,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic       gmii_txen,
    output logic [7:0] gmii_txd,
    output logic       busy,
    output logic       underrun
);

    localparam logic [10:0] MinBytes = 11'(MIN_FRAME_BYTES);
    localparam logic [15:0] IfgLast  = 16'(IFG_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle, StPreamble, StSfd, StData, StPad, StFcs, StIfg, StDrop
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [10:0] len_q, len_d, len_inc;
    logic [31:0] crc_q, crc_d, fcs;
    logic        txen_q, txen_d;
    logic [7:0]  txd_q, txd_d;
    logic        busy_q, underrun_q, underrun_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        crc_d      = crc_q;
        txen_d     = 1'b0;
        txd_d      = 8'h00;
        underrun_d = 1'b0;
        s_tready   = 1'b0;
        fcs        = ~crc_q;
        len_inc    = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;

        unique case (state_q)
            StIdle: begin
                crc_d = '1;
                len_d = '0;
                cnt_d = '0;
                if (s_tvalid) begin
                    state_d = StPreamble;
                    txen_d  = 1'b1;
                    txd_d   = 8'h55;
                end
            end
            StPreamble: begin
                txen_d = 1'b1;
                if (cnt_q == 16'd6) begin
                    txd_d   = 8'hD5;
                    cnt_d   = '0;
                    state_d = StSfd;
                end else begin
                    txd_d = 8'h55;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSfd, StData: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    txen_d  = 1'b1;
                    txd_d   = s_tdata;
                    crc_d   = crc_byte(crc_q, s_tdata);
                    len_d   = len_inc;
                    state_d = StData;
                    if (s_tlast) begin
                        cnt_d   = '0;
                        state_d = (len_inc < MinBytes) ? StPad : StFcs;
                    end
                end else begin
                    // Starved mid-frame: abort the frame and swallow the rest of it.
                    underrun_d = 1'b1;
                    state_d    = StDrop;
                end
            end
            StPad: begin
                txen_d = 1'b1;
                crc_d  = crc_byte(crc_q, 8'h00);
                len_d  = len_inc;
                if (!(len_inc < MinBytes)) begin
                    cnt_d   = '0;
                    state_d = StFcs;
                end
            end
            StFcs: begin
                txen_d = 1'b1;
                unique case (cnt_q[1:0])
                    2'd0: txd_d = fcs[7:0];
                    2'd1: txd_d = fcs[15:8];
                    2'd2: txd_d = fcs[23:16];
                    default: txd_d = fcs[31:24];
                endcase
                if (cnt_q[1:0] == 2'd3) begin
                    cnt_d   = '0;
                    state_d = StIfg;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StIfg: begin
                if (cnt_q == IfgLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDrop: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) begin
                    cnt_d   = '0;
                    state_d = StIfg;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge gmii_txc or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            len_q      <= '0;
            crc_q      <= '1;
            txen_q     <= 1'b0;
            txd_q      <= 8'h00;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            txen_q     <= txen_d;
            txd_q      <= txd_d;
            busy_q     <= (state_d != StIdle);
            underrun_q <= underrun_d;
        end
    end

    assign gmii_txen = txen_q;
    assign gmii_txd  = txd_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_eth_gmii_tx_framer.sv
// Bench for eth_gmii_tx_framer: one instance without padding, one with default padding;
// output streams are logged and compared against a frame-level reference model.
module tb_eth_gmii_tx_framer;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic       txen;
        logic [7:0] txd;
        logic       busy;
        logic       und;
        logic       tv;
        logic       acc;
        logic       last;
    } samp_t;
    typedef struct {int s; int l;} run_t;
    typedef struct {
        bit         sel;
        int         len;
        logic [7:0] base;
        logic [7:0] step;
        int         gap;
        int         exp_high;
        bit         chk_fcs;
        logic [31:0] fcs;
    } vec_t;

    localparam int Ifg = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic       rdy0, rdy1, txen0, txen1, busy0, busy1, und0, und1;
    logic [7:0] txd0, txd1;

    int    vectors = 0;
    int    miscompares = 0;
    bit    rec = 1'b0;
    samp_t log_q[$];
    run_t  runs[$];

    always #4 clk = ~clk;

    eth_gmii_tx_framer #(.MIN_FRAME_BYTES(0), .IFG_BYTES(12)) u_min0 (
        .gmii_txc(clk), .rst_n(rst_n), .s_tdata(tdata), .s_tvalid(tvalid & ~sel),
        .s_tlast(tlast), .s_tready(rdy0), .gmii_txen(txen0), .gmii_txd(txd0),
        .busy(busy0), .underrun(und0)
    );

    eth_gmii_tx_framer #(.MIN_FRAME_BYTES(60), .IFG_BYTES(12)) u_dflt (
        .gmii_txc(clk), .rst_n(rst_n), .s_tdata(tdata), .s_tvalid(tvalid & sel),
        .s_tlast(tlast), .s_tready(rdy1), .gmii_txen(txen1), .gmii_txd(txd1),
        .busy(busy1), .underrun(und1)
    );

    function automatic logic cur_ready();
        return sel ? rdy1 : rdy0;
    endfunction

    function automatic logic cur_busy();
        return sel ? busy1 : busy0;
    endfunction

    always @(negedge clk) begin : recorder
        samp_t s;
        if (rec) begin
            s.txen = sel ? txen1 : txen0;
            s.txd  = sel ? txd1 : txd0;
            s.busy = cur_busy();
            s.und  = sel ? und1 : und0;
            s.tv   = tvalid;
            s.acc  = tvalid & cur_ready();
            s.last = tlast;
            log_q.push_back(s);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Serial MSB-first form of the 802.3 CRC; FCS is the complemented bit-reversed register.
    function automatic logic [31:0] model_fcs(input bq_t d);
        logic [31:0] n, r;
        logic [7:0]  b;
        logic        fb;
        n = '1;
        foreach (d[k]) begin
            b = d[k];
            for (int i = 0; i < 8; i++) begin
                fb = n[31] ^ b[i];
                n  = n << 1;
                if (fb) n = n ^ 32'h04C1_1DB7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = n[31 - i];
        return ~r;
    endfunction

    function automatic bq_t expect_frame(input bq_t d, input int min);
        bq_t e, body;
        logic [31:0] f;
        body = d;
        while (body.size() < min) body.push_back(8'h00);
        f = model_fcs(body);
        repeat (7) e.push_back(8'h55);
        e.push_back(8'hD5);
        foreach (body[k]) e.push_back(body[k]);
        for (int i = 0; i < 4; i++) e.push_back(f[8*i +: 8]);
        return e;
    endfunction

    task automatic drive(input bq_t data, input int gap_pct, input int starve_at,
                         input int rst_at);
        int i = 0;
        int budget = 0;
        bit starved = 1'b0;
        logic acc;
        while (i < data.size()) begin
            tdata  = data[i];
            tlast  = (i == data.size() - 1);
            tvalid = 1'b1;
            if (!cur_ready() && $urandom_range(99) < gap_pct) tvalid = 1'b0;
            if (cur_ready() && i == starve_at && !starved) begin
                tvalid  = 1'b0;
                starved = 1'b1;
            end
            if (cur_ready() && i == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_async_txen", 32'(sel ? txen1 : txen0), 32'd0);
                check("rst_async_txd", 32'(sel ? txd1 : txd0), 32'd0);
                check("rst_async_ready", 32'(cur_ready()), 32'd0);
                tvalid = 1'b0;
                tlast  = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            acc = tvalid & cur_ready();
            @(posedge clk);
            #1;
            if (acc) i++;
            budget++;
            if (budget > 5000) begin
                check("drive_timeout", 32'(i), 32'(data.size()));
                break;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cur_busy() && n < 500);
        if (n >= 500) check("idle_timeout", 32'(cur_busy()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic find_runs();
        int s = 0;
        runs.delete();
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].txen && (i == 0 || !log_q[i-1].txen)) s = i;
            if (log_q[i].txen && (i == log_q.size() - 1 || !log_q[i+1].txen))
                runs.push_back('{s: s, l: i - s + 1});
        end
    endtask

    task automatic check_frame(input string name, input int r, input bq_t exp, input int exp_len);
        int n, bad;
        check({name, "_len"}, 32'(runs[r].l), 32'(exp_len));
        n   = (runs[r].l < exp.size()) ? runs[r].l : exp.size();
        bad = n - 1;
        for (int k = 0; k < n; k++) begin
            if (log_q[runs[r].s + k].txd !== exp[k]) begin
                bad = k;
                break;
            end
        end
        if (n > 0) check($sformatf("%s_byte%0d", name, bad), 32'(log_q[runs[r].s + bad].txd),
                         32'(exp[bad]));
    endtask

    task automatic ifg_check(input string name, input int r);
        int e = runs[r].s + runs[r].l;
        int k = 0;
        while (e + k < log_q.size() && log_q[e + k].busy && !log_q[e + k].txen) k++;
        check({name, "_ifg"}, 32'(k + 1), 32'(Ifg));
    endtask

    task automatic hygiene(input string name, input int exp_und);
        int u = 0;
        int z = 0;
        foreach (log_q[i]) begin
            if (log_q[i].und) u++;
            if (!log_q[i].txen && log_q[i].txd != 8'h00) z++;
        end
        check({name, "_underruns"}, 32'(u), 32'(exp_und));
        check({name, "_idle_txd"}, 32'(z), 32'd0);
    endtask

    task automatic single(input string name, input bit s, input bq_t data, input int gap,
                          input int exp_len, input bit chk_fcs, input logic [31:0] fcs);
        bq_t exp;
        int  e;
        sel = s;
        log_q.delete();
        rec = 1'b1;
        drive(data, gap, -1, -1);
        wait_idle();
        rec = 1'b0;
        find_runs();
        check({name, "_runs"}, 32'(runs.size()), 32'd1);
        if (runs.size() > 0) begin
            exp = expect_frame(data, s ? 60 : 0);
            check_frame(name, 0, exp, exp_len);
            ifg_check(name, 0);
            if (chk_fcs) begin
                e = runs[0].s + runs[0].l;
                check({name, "_fcs"}, {log_q[e-1].txd, log_q[e-2].txd, log_q[e-3].txd,
                                       log_q[e-4].txd}, fcs);
            end
        end
        hygiene(name, 0);
    endtask

    initial begin
        vec_t vt[8];
        bq_t  d, d2, exp;
        logic [7:0] b;
        int   t, s, a, k, len, acc_n, blo;

        vt[0] = '{1'b0, 9,  8'h31, 8'h01, 0,  21, 1'b1, 32'hCBF4_3926};
        vt[1] = '{1'b1, 1,  8'hAB, 8'h00, 0,  72, 1'b0, 32'h0};
        vt[2] = '{1'b1, 59, 8'h01, 8'h01, 0,  72, 1'b0, 32'h0};
        vt[3] = '{1'b1, 60, 8'h80, 8'h01, 0,  72, 1'b0, 32'h0};
        vt[4] = '{1'b1, 61, 8'hFF, 8'hFF, 0,  73, 1'b0, 32'h0};
        vt[5] = '{1'b1, 64, 8'h00, 8'h03, 25, 76, 1'b0, 32'h0};
        vt[6] = '{1'b0, 60, 8'h10, 8'h01, 20, 72, 1'b0, 32'h0};
        vt[7] = '{1'b0, 1,  8'hC3, 8'h00, 40, 13, 1'b0, 32'h0};

        // Reset state, both instances
        #3;
        check("rst_txen0", 32'(txen0), 32'd0);
        check("rst_txd0", 32'(txd0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_und0", 32'(und0), 32'd0);
        check("rst_rdy0", 32'(rdy0), 32'd0);
        check("rst_txen1", 32'(txen1), 32'd0);
        check("rst_txd1", 32'(txd1), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_rdy1", 32'(rdy1), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            d.delete();
            b = vt[v].base;
            for (int j = 0; j < vt[v].len; j++) begin
                d.push_back(b);
                b = b + vt[v].step;
            end
            single($sformatf("vec%0d", v), vt[v].sel, d, vt[v].gap, vt[v].exp_high,
                   vt[v].chk_fcs, vt[v].fcs);
        end

        // Back-to-back 64-byte frames with s_tvalid held high
        sel = 1'b1;
        d.delete();
        d2.delete();
        repeat (64) d.push_back(8'($urandom));
        repeat (64) d2.push_back(8'($urandom));
        log_q.delete();
        rec = 1'b1;
        drive(d, 0, -1, -1);
        drive(d2, 0, -1, -1);
        wait_idle();
        rec = 1'b0;
        find_runs();
        check("b2b_runs", 32'(runs.size()), 32'd2);
        if (runs.size() == 2) begin
            check_frame("b2b_f1", 0, expect_frame(d, 60), 76);
            check_frame("b2b_f2", 1, expect_frame(d2, 60), 76);
            s = runs[0].s + runs[0].l;
            check("b2b_gap", 32'(runs[1].s - s), 32'(Ifg));
            blo = 0;
            for (int i = s; i < runs[1].s; i++) if (!log_q[i].busy) blo++;
            check("b2b_busy_low", 32'(blo), 32'd1);
            ifg_check("b2b_f2", 1);
        end
        hygiene("b2b", 0);

        // Underrun after 10 accepted bytes of a 30-byte frame
        sel = 1'b1;
        d.delete();
        repeat (30) d.push_back(8'($urandom_range(1, 255)));
        log_q.delete();
        rec = 1'b1;
        drive(d, 0, 10, -1);
        wait_idle();
        rec = 1'b0;
        find_runs();
        check("urun_runs", 32'(runs.size()), 32'd1);
        if (runs.size() > 0) begin
            check_frame("urun", 0, expect_frame(d, 60), 18);
            s = runs[0].s + runs[0].l;
            if (s < log_q.size()) check("urun_pulse_pos", 32'(log_q[s].und), 32'd1);
        end
        hygiene("urun", 1);
        acc_n = 0;
        a = -1;
        foreach (log_q[i]) begin
            if (log_q[i].acc) acc_n++;
            if (log_q[i].acc && log_q[i].last) a = i;
        end
        check("urun_accepted", 32'(acc_n), 32'd30);
        k = 0;
        if (a >= 0) while (a + 1 + k < log_q.size() && log_q[a + 1 + k].busy) k++;
        check("urun_ifg", 32'(k), 32'(Ifg));

        // Reset during data byte 30, then a clean frame
        sel = 1'b1;
        d.delete();
        repeat (64) d.push_back(8'($urandom));
        drive(d, 0, -1, 29);
        repeat (2) @(posedge clk);
        #1;
        d.delete();
        repeat (20) d.push_back(8'($urandom));
        single("post_rst", 1'b1, d, 0, 72, 1'b0, 32'h0);

        // Idle gaps before a single-byte frame, no padding
        sel = 1'b0;
        d.delete();
        d.push_back(8'h5A);
        log_q.delete();
        rec = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        drive(d, 60, -1, -1);
        wait_idle();
        rec = 1'b0;
        find_runs();
        check("gap_runs", 32'(runs.size()), 32'd1);
        t = -1;
        foreach (log_q[i]) if (t < 0 && log_q[i].tv) t = i;
        if (runs.size() > 0) begin
            s = runs[0].s;
            check("gap_start", 32'(s), 32'(t + 1));
            if (s > 0) check("gap_busy_t0", 32'(log_q[s-1].busy), 32'd0);
            check("gap_busy_t1", 32'(log_q[s].busy), 32'd1);
            check_frame("gap", 0, expect_frame(d, 0), 13);
            ifg_check("gap", 0);
        end

        // Randomized frames against the reference model
        for (int r = 0; r < 16; r++) begin
            len = $urandom_range(1, 90);
            d.delete();
            repeat (len) d.push_back(8'($urandom));
            s = $urandom_range(1);
            single($sformatf("rnd%0d", r), s[0], d, 30,
                   8 + ((s[0] && len < 60) ? 60 : len) + 4, 1'b0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
